rr_arbiter_32: RTL and testbench

RR_ARBITER_32 -- requirements
Module: rr_arbiter_32

---
 rtl/rr_arbiter_32_pkg.sv | 15 +
 rtl/rr_pri_enc_32.sv | 45 ++++
 rtl/rr_arbiter_32.sv | 101 ++++++++++
 tb/tb_rr_arbiter_32.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_32_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_32_pkg
// Shared constants for the 32-way round-robin arbiter: requester count,
// select width and the two-state controller encodings.
// -----------------------------------------------------------------------------
package rr_arbiter_32_pkg;

    localparam int NUM_REQ = 32;
    localparam int SEL_W   = 5;

    localparam int STATE_W = 1;
    localparam logic [STATE_W-1:0] ST_IDLE = 1'b0;
    localparam logic [STATE_W-1:0] ST_BUSY = 1'b1;

endpackage : rr_arbiter_32_pkg

// File: rtl/rr_pri_enc_32.sv
// -----------------------------------------------------------------------------
// rr_pri_enc_32
// Purely combinational circular priority encoder. Finds the first set bit of
// vec_i searching upward from start_i and wrapping past bit 31 to bit 0.
//
// Ports
//   vec_i    [31:0]  candidate vector
//   start_i  [4:0]   highest-priority bit position
//   found_o          at least one bit of vec_i is set
//   idx_o    [4:0]   index of the winning bit (don't-care when !found_o)
// -----------------------------------------------------------------------------
module rr_pri_enc_32
    import rr_arbiter_32_pkg::*;
(
    input  logic [NUM_REQ-1:0] vec_i,
    input  logic [SEL_W-1:0]   start_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   idx_o
);

    // Rotate so that start_i lands on bit 0; the 5-bit add wraps naturally,
    // which turns the circular search into a plain lowest-set-bit search.
    logic [NUM_REQ-1:0] rot;
    logic [SEL_W-1:0]   pos;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
            assign rot[gi] = vec_i[start_i + SEL_W'(gi)];
        end
    endgenerate

    always_comb begin
        pos = '0;
        // Descending scan so the lowest set bit is the last assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                pos = SEL_W'(i);
            end
        end
    end

    assign found_o = |rot;
    assign idx_o   = start_i + pos;

endmodule : rr_pri_enc_32

// File: rtl/rr_arbiter_32.sv
// -----------------------------------------------------------------------------
// rr_arbiter_32
// 32-requester round-robin arbiter steering a shared 32-input mux. A request
// seen in IDLE is granted one cycle later; the grant holds until out_ready
// completes a handshake, in which cycle the next winner is picked
// back-to-back (excluding the requester just served).
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous active-high reset
//   req       [31:0] request vector, bit i = requester i
//   out_ready        downstream accepts the selected word this cycle
//   select    [4:0]  mux select, index of the granted requester
//   grant     [31:0] one-hot grant, zero when idle
//   out_valid        mux output valid this cycle
//   done      [31:0] per-requester acknowledge (grant & out_ready), combinational
// -----------------------------------------------------------------------------
module rr_arbiter_32
    import rr_arbiter_32_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   select,
    output logic [NUM_REQ-1:0] grant,
    output logic               out_valid,
    output logic [NUM_REQ-1:0] done
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SEL_W-1:0]   ptr_q,   ptr_d;
    logic [SEL_W-1:0]   sel_q,   sel_d;

    logic [NUM_REQ-1:0] enc_vec;
    logic [SEL_W-1:0]   enc_start;
    logic               enc_found;
    logic [SEL_W-1:0]   enc_idx;
    logic               busy;

    assign busy      = (state_q == ST_BUSY);
    assign out_valid = busy;
    assign select    = sel_q;
    // Grant is decoded from registered state only, so it moves on edges.
    assign grant     = busy ? (NUM_REQ'(1) << sel_q) : '0;
    assign done      = (busy && out_ready) ? grant : '0;

    // In IDLE search from the pointer; in BUSY the encoder result is only
    // used on a handshake, where the served requester is masked out and the
    // search starts just past it (equal to the pointer it is about to get).
    assign enc_vec   = busy ? (req & ~grant) : req;
    assign enc_start = busy ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_pri_enc_32 u_pri_enc (
        .vec_i   (enc_vec),
        .start_i (enc_start),
        .found_o (enc_found),
        .idx_o   (enc_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            ST_IDLE: begin
                if (enc_found) begin
                    state_d = ST_BUSY;
                    sel_d   = enc_idx;
                end
            end
            ST_BUSY: begin
                // Without out_ready everything holds; req changes are ignored.
                if (out_ready) begin
                    ptr_d = sel_q + SEL_W'(1);
                    if (enc_found) begin
                        sel_d = enc_idx;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

endmodule : rr_arbiter_32

// File: tb/tb_rr_arbiter_32.sv
module tb_rr_arbiter_32;

    logic        clock;
    logic        reset;
    logic [31:0] req;
    logic        out_ready;
    logic [4:0]  select;
    logic [31:0] grant;
    logic        out_valid;
    logic [31:0] done;

    rr_arbiter_32 dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .out_ready (out_ready),
        .select    (select),
        .grant     (grant),
        .out_valid (out_valid),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        valid;
        logic [4:0]  sel;
        logic [31:0] grant;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        bit          rst;
        logic [31:0] req;
        bit          rdy;
        bit          exp_valid;
        logic [4:0]  exp_sel;
        logic [31:0] exp_grant;
    } vec_t;

    // Reference model state
    bit         m_state;
    logic [4:0] m_ptr;
    logic [4:0] m_sel;
    int         wait_cnt [32];

    function automatic logic [31:0] m_grant_f(input bit st, input logic [4:0] s);
        logic [31:0] g;
        g = '0;
        if (st) g[s] = 1'b1;
        return g;
    endfunction

    function automatic bit search(input logic [31:0] v, input int s, output logic [4:0] w);
        w = '0;
        for (int k = 0; k < 32; k++) begin
            if (v[(s + k) % 32]) begin
                w = 5'((s + k) % 32);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic step(input bit rst, input logic [31:0] r, input bit rdy);
        logic [31:0] exp_done;
        logic [4:0]  w;
        bit          f;
        bit          hs;
        exp_t        e;
        exp_t        got;
        int          mx;
        reset     = rst;
        req       = r;
        out_ready = rdy;
        #1;
        // Combinational acknowledge against the model's current outputs
        exp_done = (m_state && rdy) ? m_grant_f(m_state, m_sel) : 32'h0;
        n_vec++;
        if (done !== exp_done) begin
            n_err++;
            $display("FAIL done: got %h want %h", done, exp_done);
        end
        // Starvation bookkeeping on observed handshakes
        hs = out_valid && rdy && !rst;
        mx = 0;
        for (int i = 0; i < 32; i++) begin
            if (rst || !r[i]) wait_cnt[i] = 0;
            else if (hs) begin
                if (int'(select) == i) wait_cnt[i] = 0;
                else wait_cnt[i]++;
            end
            if (wait_cnt[i] > mx) mx = wait_cnt[i];
        end
        if (hs) begin
            n_vec++;
            if (mx > 31) begin
                n_err++;
                $display("FAIL starve: got wait %0d want <= 31", mx);
            end
        end
        // Model next state, pushed to scoreboard
        if (rst) begin
            m_state = 1'b0; m_ptr = '0; m_sel = '0;
        end else if (!m_state) begin
            f = search(r, int'(m_ptr), w);
            if (f) begin m_state = 1'b1; m_sel = w; end
        end else if (rdy) begin
            f = search(r & ~m_grant_f(m_state, m_sel), (int'(m_sel) + 1) % 32, w);
            m_ptr = m_sel + 5'd1;
            if (f) m_sel = w;
            else m_state = 1'b0;
        end
        e.valid = m_state;
        e.sel   = m_sel;
        e.grant = m_grant_f(m_state, m_sel);
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        got.valid = out_valid; got.sel = select; got.grant = grant;
        n_vec++;
        if ({got.valid, got.sel, got.grant} !== {e.valid, e.sel, e.grant}) begin
            n_err++;
            $display("FAIL model: got v=%b sel=%0d g=%h want v=%b sel=%0d g=%h",
                     got.valid, got.sel, got.grant, e.valid, e.sel, e.grant);
        end
        // Structural integrity of the outputs
        n_vec++;
        if (!((grant == 32'h0 && !out_valid) ||
              (out_valid && $onehot(grant) && grant == (32'h1 << select)))) begin
            n_err++;
            $display("FAIL onehot: got v=%b sel=%0d g=%h want one-hot grant matching select",
                     out_valid, select, grant);
        end
    endtask

    vec_t tbl [22];

    initial begin
        reset = 1'b1; req = '0; out_ready = 1'b0;
        m_state = 1'b0; m_ptr = '0; m_sel = '0;
        for (int i = 0; i < 32; i++) wait_cnt[i] = 0;

        // rst, req, rdy, expected valid/select/grant after the edge
        tbl[0]  = '{1, 32'h0000_0000, 0, 0, 5'd0,  32'h0000_0000};
        tbl[1]  = '{0, 32'h0000_0001, 1, 1, 5'd0,  32'h0000_0001};
        tbl[2]  = '{0, 32'h0000_0001, 1, 0, 5'd0,  32'h0000_0000};
        tbl[3]  = '{0, 32'h0000_0020, 0, 1, 5'd5,  32'h0000_0020};
        tbl[4]  = '{0, 32'h0000_0100, 0, 1, 5'd5,  32'h0000_0020};
        tbl[5]  = '{0, 32'h0000_0100, 0, 1, 5'd5,  32'h0000_0020};
        tbl[6]  = '{0, 32'h0000_0100, 0, 1, 5'd5,  32'h0000_0020};
        tbl[7]  = '{0, 32'h0000_0100, 0, 1, 5'd5,  32'h0000_0020};
        tbl[8]  = '{0, 32'h0000_0100, 1, 1, 5'd8,  32'h0000_0100};
        tbl[9]  = '{0, 32'h8000_0000, 1, 1, 5'd31, 32'h8000_0000};
        tbl[10] = '{0, 32'h8000_0001, 1, 1, 5'd0,  32'h0000_0001};
        tbl[11] = '{0, 32'h8000_0001, 1, 1, 5'd31, 32'h8000_0000};
        tbl[12] = '{0, 32'h0000_0000, 1, 0, 5'd31, 32'h0000_0000};
        tbl[13] = '{0, 32'h0000_0010, 0, 1, 5'd4,  32'h0000_0010};
        tbl[14] = '{1, 32'h0000_0010, 0, 0, 5'd0,  32'h0000_0000};
        tbl[15] = '{0, 32'h0000_0006, 0, 1, 5'd1,  32'h0000_0002};
        tbl[16] = '{0, 32'h0000_0000, 0, 1, 5'd1,  32'h0000_0002};
        tbl[17] = '{0, 32'h0000_0000, 1, 0, 5'd1,  32'h0000_0000};
        tbl[18] = '{0, 32'h0000_0004, 1, 1, 5'd2,  32'h0000_0004};
        tbl[19] = '{0, 32'h0000_0004, 1, 0, 5'd2,  32'h0000_0000};
        tbl[20] = '{0, 32'h0000_0004, 1, 1, 5'd2,  32'h0000_0004};
        tbl[21] = '{0, 32'h0000_0000, 1, 0, 5'd2,  32'h0000_0000};

        @(posedge clock);
        #1;

        for (int t = 0; t < 22; t++) begin
            step(tbl[t].rst, tbl[t].req, tbl[t].rdy);
            n_vec++;
            if ({out_valid, select, grant} !== {tbl[t].exp_valid, tbl[t].exp_sel, tbl[t].exp_grant}) begin
                n_err++;
                $display("FAIL table[%0d]: got v=%b sel=%0d g=%h want v=%b sel=%0d g=%h",
                         t, out_valid, select, grant,
                         tbl[t].exp_valid, tbl[t].exp_sel, tbl[t].exp_grant);
            end
            $display("vec %0d: rst=%b req=%h rdy=%b -> v=%b sel=%0d g=%h",
                     t, tbl[t].rst, tbl[t].req, tbl[t].rdy, out_valid, select, grant);
        end

        // Full-load rotation from reset: 0,1,...,31,0,1 with no bubbles
        step(1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 34; k++) begin
            step(1'b0, 32'hFFFF_FFFF, 1'b1);
            n_vec++;
            if (!out_valid || select !== 5'(k % 32)) begin
                n_err++;
                $display("FAIL rotate[%0d]: got v=%b sel=%0d want v=1 sel=%0d",
                         k, out_valid, select, k % 32);
            end
        end
        $display("rotation: 34 grants checked");

        // Random traffic with occasional reset
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] r;
            bit          rdy;
            bit          rst;
            case ($urandom_range(0, 3))
                0: r = $urandom;
                1: r = $urandom & $urandom & $urandom;
                2: r = 32'h1 << $urandom_range(0, 31);
                default: r = ~($urandom & $urandom);
            endcase
            rdy = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            step(rst, r, rdy);
        end
        $display("random: 10000 cycles applied");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_arbiter_32
